// File: rtl/mem16x8_responder.sv
// Purpose: 16x8 CPU-side memory with a clear/load controller that holds the CPU in reset until contents are valid.
// Latency: reads are combinational in RUN. Writes and load bytes commit on the next rising edge. Clearing takes DEPTH cycles.
// Backpressure: load_ready is high only in LOAD. CPU accesses are ignored outside RUN, and load bytes are ignored outside LOAD.
//
// Ports:
//   clk, reset                 - rising-edge clock; synchronous active-high reset
//   read, write, address       - CPU access strobes and word address
//   memoryIn / memoryOut       - CPU write data / read data (0 when not reading in RUN)
//   load_start                 - request a load session (honoured only in RUN)
//   load_valid/load_data       - load byte stream; load_ready is high while in LOAD
//   load_done                  - one-cycle pulse after the last load byte is accepted
//   cpu_hold                   - keep the CPU in reset (high in CLEAR, in LOAD, and during reset)
//   access_err                 - sticky flag for a read+write conflict in RUN
module mem16x8_responder #(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int DW         = 8,
    parameter int LOAD_WORDS = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          read,
    input  logic          write,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] memoryIn,
    output logic [DW-1:0] memoryOut,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    output logic          load_done,
    output logic          cpu_hold,
    output logic          access_err
);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } stateT;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LOAD_LAST = AW'(LOAD_WORDS - 1);

    logic [DW-1:0] mem [DEPTH];

    stateT         state, nextState;
    logic [AW-1:0] ptr, nextPtr;
    logic          loadDone, nextLoadDone;
    logic          accessErr, setErr;
    logic          memWe;
    logic [AW-1:0] memWaddr;
    logic [DW-1:0] memWdata;

    // Next-state logic and the single memory write port.
    // CLEAR, LOAD and CPU writes never write in the same cycle, so one port is enough.
    always_comb begin
        nextState    = state;
        nextPtr      = ptr;
        nextLoadDone = 1'b0;
        setErr       = 1'b0;
        memWe        = 1'b0;
        memWaddr     = ptr;
        memWdata     = '0;
        case (state)
            CLEAR: begin
                memWe   = 1'b1;
                nextPtr = ptr + AW'(1);
                if (ptr == LAST_ADDR) begin
                    nextState = RUN;
                    nextPtr   = '0;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    memWe    = 1'b1;
                    memWdata = load_data;
                    nextPtr  = ptr + AW'(1);
                    if (ptr == LOAD_LAST) begin
                        nextState    = RUN;
                        nextPtr      = '0;
                        nextLoadDone = 1'b1;
                    end
                end
            end
            RUN: begin
                // A simultaneous read and write is a CPU protocol error. Only the read is honoured.
                if (read && write) begin
                    setErr = 1'b1;
                end else if (write) begin
                    memWe    = 1'b1;
                    memWaddr = address;
                    memWdata = memoryIn;
                end
                if (load_start) begin
                    nextState = LOAD;
                    nextPtr   = '0;
                end
            end
            default: begin
                nextState = CLEAR;
                nextPtr   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            ptr       <= '0;
            loadDone  <= 1'b0;
            accessErr <= 1'b0;
        end else begin
            state    <= nextState;
            ptr      <= nextPtr;
            loadDone <= nextLoadDone;
            if (setErr) begin
                accessErr <= 1'b1;
            end
        end
    end

    // Memory is deliberately not written on a reset edge.
    // A discarded partial load is wiped by the CLEAR pass that follows.
    always_ff @(posedge clk) begin
        if (!reset && memWe) begin
            mem[memWaddr] <= memWdata;
        end
    end

    // The reset qualifiers make the outputs correct while reset is held,
    // before the first reset edge has put the state register into CLEAR.
    assign memoryOut  = (state == RUN && read && !reset) ? mem[address] : '0;
    assign load_ready = (state == LOAD) && !reset;
    assign cpu_hold   = reset || (state != RUN);
    assign load_done  = loadDone;
    assign access_err = accessErr;

endmodule
